icache_refill_bridge: RTL and testbench
=======================================

# icache_refill_bridge

Read-bus slave that serves the instruction cache's block-refill requests. It accepts one block-read command per refill and breaks it into BLK_LEN single-word reads on a word-wide memory port, with up to BLK_LEN reads outstanding. It assembles the returned words into one cache line and hands the line back to the ICache in a single-cycle valid pulse. It sits directly downstream of the ICache read-bus interface (mem_*) and upstream of instruction memory (dev_*).

## Interface
- BLK_LEN, 4, words per cache block; a power of two ≥ 2.
- BLK_SIZE, BLK_LEN*32, block width in bits.
- cpu_clk  in  1  clock; all state changes on the rising edge.
- cpu_rstn  in  1  reset; asynchronous and active-low.
- mem_rrdy  out  1  bridge idle and able to accept a block read.
- mem_ren  in  4  block-read request from the ICache; any nonzero value counts as a request.
- mem_raddr  in  32  block-read address; sampled only when the request is accepted.
- mem_rvalid  out  1  one-cycle pulse; mem_rdata holds the complete block.
- mem_rdata  out  BLK_SIZE  assembled block; word i is at bits [32i+31:32i].
- dev_ren  out  1  word read request to memory.
- dev_raddr  out  32  word address for dev_ren.
- dev_rrdy  in  1  memory accepts dev_ren in this cycle.
- dev_rvalid  in  1  a read word is returned in this cycle; words return in request order.
- dev_rdata  in  32  returned word.

## Operation
- States:
  - IDLE: mem_rrdy=1.
  - ISSUE: dev_ren=1.
  - WAIT: all reads issued; collecting the rest of the responses.
  - DONE: mem_rvalid=1.
- IDLE→ISSUE: on a cycle with mem_rrdy=1 and mem_ren≠0.
  - Latch base = mem_raddr with bits [log2(BLK_LEN)+1:0] forced to 0.
  - Clear issue_cnt and recv_cnt.
- ISSUE:
  - dev_raddr = base + 4*issue_cnt.
  - A handshake (dev_ren & dev_rrdy) increments issue_cnt.
  - After the BLK_LEN-th handshake, go to WAIT. If that same edge also captures the last response, go straight to DONE.
- Response capture, in both ISSUE and WAIT:
  - dev_rvalid=1 writes dev_rdata into line word recv_cnt and increments recv_cnt.
  - Capture is independent of issue handshakes in the same cycle.
- WAIT→DONE: on the edge that captures response number BLK_LEN.
- DONE→IDLE: unconditionally, after one cycle.
- Counters are log2(BLK_LEN)+1 bits wide.
- Address arithmetic: base is block-aligned, so base+4*(BLK_LEN-1) never carries out of the block. Bits [31:log2(BLK_LEN)+2] of dev_raddr equal base for every beat.
- mem_rdata is a register. It updates word by word during a fill and holds the last complete block until the next fill overwrites it.
- mem_rrdy, mem_rvalid and dev_ren are decoded from the state register only; there is no combinational path from any input to any output.
- Boundary conditions:
  - mem_ren≠0 while not IDLE: ignored; no second fill is queued.
  - dev_rvalid in IDLE or DONE: ignored.
  - dev_rrdy=0 in ISSUE: dev_ren and dev_raddr hold stable until accepted.
  - dev_rrdy outside ISSUE: ignored.
  - Reset mid-fill: the state returns to IDLE immediately. Responses still in flight after reset release are ignored because the state is IDLE.

## Timing
- Reset values: state IDLE, mem_rrdy=1, mem_rvalid=0, mem_rdata=0, dev_ren=0, dev_raddr=0, both counters 0.
- Example, request accepted at the edge ending cycle T, with dev_rrdy held at 1 and memory answering one cycle after acceptance:
  - dev_ren=1 in cycles T+1..T+BLK_LEN.
  - dev_rvalid in cycles T+2..T+BLK_LEN+1.
  - mem_rvalid=1 in cycle T+BLK_LEN+2.
  - mem_rrdy=1 again from cycle T+BLK_LEN+3.
- Minimum latency from request to mem_rvalid is BLK_LEN+2 cycles; with BLK_LEN=4 that is 6 cycles.
- mem_rvalid is exactly one cycle wide. mem_rdata is valid in that cycle and stays valid afterwards.
- Minimum interval between two accepted requests is BLK_LEN+3 cycles.

## Test plan
- Basic fill:
  - Stimulus: mem_ren=4'hF, mem_raddr=0x0000_1234; dev_rrdy=1; memory returns word 0x1000_0000+addr one cycle after acceptance.
  - Required: dev_raddr sequence 0x1230, 0x1234, 0x1238, 0x123C. mem_rvalid in cycle T+6. mem_rdata = {0x1000_123C, 0x1000_1238, 0x1000_1234, 0x1000_1230}.
- Backpressure:
  - Stimulus: dev_rrdy toggles 0,1,0,0,1,… during the fill.
  - Required: dev_raddr is stable while dev_rrdy=0, exactly 4 handshakes occur, and the data matches the basic-fill case.
- Slow and bursty responses:
  - Stimulus: all 4 reads accepted back-to-back, then responses arrive 5, 6, 9 and 10 cycles later.
  - Required: the state reaches WAIT, mem_rvalid pulses the cycle after the 4th response, and word order is correct.
- Busy request ignored:
  - Stimulus: a second mem_ren=4'hF with mem_raddr=0x2000 issued during ISSUE.
  - Required: no dev_ren ever carries 0x2000, and mem_rvalid pulses exactly once.
- Reset mid-fill:
  - Stimulus: cpu_rstn low after 2 responses, then released while stale dev_rvalid pulses continue.
  - Required: the bridge is in IDLE with mem_rrdy=1, mem_rdata=0 and mem_rvalid=0. A fresh fill afterwards completes correctly.
- Top-of-memory address:
  - Stimulus: mem_raddr=0xFFFF_FFFC.
  - Required: dev_raddr sequence 0xFFFF_FFF0..0xFFFF_FFFC with no wrap to 0.

Source files
------------

// File: rtl/icache_refill_bridge.sv
// Block-refill bridge: turns one ICache block-read command into BLK_LEN
// pipelined word reads and returns the assembled line in a one-cycle pulse.
module icache_refill_bridge #(
  parameter int BLK_LEN  = 4,
  parameter int BLK_SIZE = BLK_LEN * 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rstn,
  output logic                mem_rrdy,
  input  logic [3:0]          mem_ren,
  input  logic [31:0]         mem_raddr,
  output logic                mem_rvalid,
  output logic [BLK_SIZE-1:0] mem_rdata,
  output logic                dev_ren,
  output logic [31:0]         dev_raddr,
  input  logic                dev_rrdy,
  input  logic                dev_rvalid,
  input  logic [31:0]         dev_rdata
);

  localparam int IDX_W = $clog2(BLK_LEN);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [31-OFF_W:0]      base_blk;
  logic [CNT_W-1:0]       issue_cnt;
  logic [CNT_W-1:0]       recv_cnt;
  logic                   accept;
  logic                   issue_hs;
  logic                   capture;
  logic                   issue_last;
  logic                   recv_last;

  // Offset bits of the request address are discarded by block alignment.
  logic unused_raddr_lo;
  assign unused_raddr_lo = ^mem_raddr[OFF_W-1:0];

  assign accept     = (state == IDLE) && (mem_ren != 4'b0000);
  assign issue_hs   = (state == ISSUE) && dev_rrdy;
  assign capture    = ((state == ISSUE) || (state == WAIT)) && dev_rvalid;
  assign issue_last = issue_hs && (issue_cnt == CNT_W'(BLK_LEN - 1));
  assign recv_last  = capture && (recv_cnt == CNT_W'(BLK_LEN - 1));

  // Base is block-aligned, so the beat offset is a plain concatenation.
  assign dev_raddr = {base_blk, issue_cnt[IDX_W-1:0], 2'b00};

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_rrdy   = 1'b0;
    mem_rvalid = 1'b0;
    dev_ren    = 1'b0;
    case (state)
      IDLE: begin
        mem_rrdy = 1'b1;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        dev_ren = 1'b1;
        if (issue_last) state_nxt = recv_last ? DONE : WAIT;
      end
      WAIT: begin
        if (recv_last) state_nxt = DONE;
      end
      DONE: begin
        mem_rvalid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      base_blk  <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (accept) begin
      base_blk  <= mem_raddr[31:OFF_W];
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      if (issue_hs) issue_cnt <= issue_cnt + CNT_W'(1);
      if (capture)  recv_cnt  <= recv_cnt + CNT_W'(1);
    end
  end

  // The line register keeps the last complete block between fills.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      mem_rdata <= '0;
    end else begin
      for (int i = 0; i < BLK_LEN; i++) begin
        if (capture && (recv_cnt[IDX_W-1:0] == IDX_W'(i))) begin
          mem_rdata[32*i +: 32] <= dev_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge with an in-order memory responder
// whose per-beat latency and accept pattern are set by each test.
module tb_icache_refill_bridge;

  logic         cpu_clk;
  logic         cpu_rstn;
  logic         mem_rrdy;
  logic [3:0]   mem_ren;
  logic [31:0]  mem_raddr;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         dev_ren;
  logic [31:0]  dev_raddr;
  logic         dev_rrdy;
  logic         dev_rvalid;
  logic [31:0]  dev_rdata;

  icache_refill_bridge #(.BLK_LEN(4)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .mem_rrdy   (mem_rrdy),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dev_ren    (dev_ren),
    .dev_raddr  (dev_raddr),
    .dev_rrdy   (dev_rrdy),
    .dev_rvalid (dev_rvalid),
    .dev_rdata  (dev_rdata)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_mis = 0;

  int           cyc = 0;
  int           hs_n, rsp_n;
  int           hs_cyc [8];
  logic [31:0]  hs_addr [8];
  int           dly [4];
  bit           stale;
  bit           bp_mode;
  int           bp_idx;
  bit           bp_pat [5];
  bit           prev_stall;
  logic [31:0]  prev_addr;
  int           stab_err;
  bit           saw_2000;
  int           rv_cnt, rv_cyc;
  logic [127:0] rv_data;
  int           wait_seen;
  int           lat;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive responder/ready after the edge, observe at negedge.
  task automatic tick();
    @(posedge cpu_clk);
    cyc++;
    #1;
    if (stale) begin
      dev_rvalid = 1'b1;
      dev_rdata  = 32'hDEAD_BEEF;
    end else if (rsp_n < hs_n && cyc >= hs_cyc[rsp_n] + dly[rsp_n]) begin
      dev_rvalid = 1'b1;
      dev_rdata  = 32'h1000_0000 + hs_addr[rsp_n];
      rsp_n++;
    end else begin
      dev_rvalid = 1'b0;
      dev_rdata  = 32'h0;
    end
    if (bp_mode) begin
      dev_rrdy = bp_pat[bp_idx % 5];
      bp_idx++;
    end else begin
      dev_rrdy = 1'b1;
    end
    @(negedge cpu_clk);
    if (dev_ren) begin
      if (prev_stall && dev_raddr != prev_addr) stab_err++;
      if (dev_raddr[31:4] == 28'h000_0200) saw_2000 = 1'b1;
      if (dev_rrdy && hs_n < 8) begin
        hs_addr[hs_n] = dev_raddr;
        hs_cyc[hs_n]  = cyc;
        hs_n++;
      end
      prev_stall = !dev_rrdy;
      prev_addr  = dev_raddr;
    end else begin
      prev_stall = 1'b0;
    end
    if (mem_rvalid) begin
      rv_cnt++;
      rv_cyc  = cyc;
      rv_data = mem_rdata;
    end
    if (!dev_ren && !mem_rvalid && !mem_rrdy) wait_seen++;
  endtask

  task automatic do_fill(input logic [31:0] addr, input bit busy, output int latency);
    int t0;
    hs_n = 0; rsp_n = 0; rv_cnt = 0; wait_seen = 0; bp_idx = 0;
    prev_stall = 1'b0; stab_err = 0; saw_2000 = 1'b0;
    check_eq("rrdy_before_fill", 128'(mem_rrdy), 128'(1));
    mem_ren   = 4'hF;
    mem_raddr = addr;
    t0 = cyc;
    tick();
    mem_ren   = 4'h0;
    mem_raddr = 32'h0;
    for (int i = 0; i < 60 && rv_cnt == 0; i++) begin
      if (busy && i < 2) begin
        mem_ren   = 4'hF;
        mem_raddr = 32'h0000_2000;
      end else begin
        mem_ren   = 4'h0;
        mem_raddr = 32'h0;
      end
      tick();
    end
    mem_ren = 4'h0;
    if (rv_cnt == 0) check_eq("fill_timeout", 128'(0), 128'(1));
    latency = rv_cyc - t0;
    tick();
    check_eq("rrdy_after_done", 128'(mem_rrdy), 128'(1));
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cpu_rstn = 1'b0; mem_ren = 4'h0; mem_raddr = 32'h0;
    dev_rrdy = 1'b0; dev_rvalid = 1'b0; dev_rdata = 32'h0;
    stale = 1'b0; bp_mode = 1'b0; bp_idx = 0;
    bp_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dly = '{1, 1, 1, 1};
    hs_n = 0; rsp_n = 0; rv_cnt = 0;
    tick();
    tick();
    check_eq("rst_mem_rrdy",   128'(mem_rrdy),   128'(1));
    check_eq("rst_mem_rvalid", 128'(mem_rvalid), 128'(0));
    check_eq("rst_mem_rdata",  mem_rdata,        128'(0));
    check_eq("rst_dev_ren",    128'(dev_ren),    128'(0));
    check_eq("rst_dev_raddr",  128'(dev_raddr),  128'(0));
    cpu_rstn = 1'b1;
    tick();

    // Basic fill
    do_fill(32'h0000_1234, 1'b0, lat);
    check_eq("basic_addrs", {hs_addr[3], hs_addr[2], hs_addr[1], hs_addr[0]},
             128'h0000_123C_0000_1238_0000_1234_0000_1230);
    check_eq("basic_hs_count", 128'(hs_n), 128'(4));
    check_eq("basic_latency", 128'(lat), 128'(6));
    check_eq("basic_data", rv_data, 128'h1000_123C_1000_1238_1000_1234_1000_1230);
    check_eq("basic_pulses", 128'(rv_cnt), 128'(1));
    check_eq("basic_data_held", mem_rdata, 128'h1000_123C_1000_1238_1000_1234_1000_1230);

    // Backpressure: handshakes at T+2, T+5, T+7, T+10 -> done at T+12
    bp_mode = 1'b1;
    do_fill(32'h0000_1234, 1'b0, lat);
    bp_mode = 1'b0;
    check_eq("bp_stable", 128'(stab_err), 128'(0));
    check_eq("bp_hs_count", 128'(hs_n), 128'(4));
    check_eq("bp_addrs", {hs_addr[3], hs_addr[2], hs_addr[1], hs_addr[0]},
             128'h0000_123C_0000_1238_0000_1234_0000_1230);
    check_eq("bp_data", rv_data, 128'h1000_123C_1000_1238_1000_1234_1000_1230);
    check_eq("bp_latency", 128'(lat), 128'(12));

    // Slow responses: at T+6, T+8, T+12, T+14 -> done at T+15
    dly = '{5, 6, 9, 10};
    do_fill(32'h0000_5670, 1'b0, lat);
    dly = '{1, 1, 1, 1};
    check_eq("slow_wait_seen", 128'(wait_seen > 0), 128'(1));
    check_eq("slow_latency", 128'(lat), 128'(15));
    check_eq("slow_data", rv_data, 128'h1000_567C_1000_5678_1000_5674_1000_5670);
    check_eq("slow_pulses", 128'(rv_cnt), 128'(1));

    // Busy request ignored
    do_fill(32'h0000_1234, 1'b1, lat);
    check_eq("busy_no_2000", 128'(saw_2000), 128'(0));
    check_eq("busy_pulses", 128'(rv_cnt), 128'(1));
    check_eq("busy_hs_count", 128'(hs_n), 128'(4));
    check_eq("busy_data", rv_data, 128'h1000_123C_1000_1238_1000_1234_1000_1230);

    // Reset mid-fill with stale responses across release
    hs_n = 0; rsp_n = 0; rv_cnt = 0;
    mem_ren = 4'hF; mem_raddr = 32'h0000_4440;
    tick();
    mem_ren = 4'h0; mem_raddr = 32'h0;
    for (int i = 0; i < 20 && rsp_n < 2; i++) tick();
    tick();
    cpu_rstn = 1'b0;
    stale = 1'b1;
    tick();
    check_eq("rst_mid_rdata", mem_rdata, 128'(0));
    tick();
    cpu_rstn = 1'b1;
    rv_cnt = 0;
    tick();
    tick();
    tick();
    check_eq("rst_mid_rrdy",   128'(mem_rrdy),  128'(1));
    check_eq("rst_mid_rdata2", mem_rdata,       128'(0));
    check_eq("rst_mid_rvalid", 128'(rv_cnt),    128'(0));
    check_eq("rst_mid_dev_ren", 128'(dev_ren),  128'(0));
    stale = 1'b0;
    tick();
    do_fill(32'h0000_1234, 1'b0, lat);
    check_eq("post_rst_data", rv_data, 128'h1000_123C_1000_1238_1000_1234_1000_1230);
    check_eq("post_rst_latency", 128'(lat), 128'(6));

    // Top-of-memory block
    do_fill(32'hFFFF_FFFC, 1'b0, lat);
    check_eq("top_addrs", {hs_addr[3], hs_addr[2], hs_addr[1], hs_addr[0]},
             128'hFFFF_FFFC_FFFF_FFF8_FFFF_FFF4_FFFF_FFF0);
    check_eq("top_data", rv_data, 128'h0FFF_FFFC_0FFF_FFF8_0FFF_FFF4_0FFF_FFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
